emu_vec_sequencer: RTL and testbench

Host-side transactor that sits directly upstream of an emulation wrapper and drives its Din_emu/Addr_emu/load_emu/get_emu/clk_dut interface. It accepts a byte stream from the host link (UART RX or similar) and writes NUM_STIM stimulus bytes into the wrapper. It then pulses load, advances the DUT by one clk_dut period, and pulses get. Finally it reads NUM_OUT response bytes back and returns them on a byte stream to the host link. One stimulus vector in produces one response vector out, with no host-side handshaking beyond valid/ready.

---
 rtl/emu_seq_pkg.sv | 27 ++
 rtl/emu_vec_sequencer_if.sv | 40 ++++
 rtl/emu_clk_pulse.sv | 81 ++++++++
 rtl/emu_vec_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_emu_vec_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/emu_seq_pkg.sv
// ---------------------------------------------------------------------------
// emu_seq_pkg : shared types and constants for the emulation vector sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package emu_seq_pkg;

   localparam int BYTE_W    = 8;
   localparam int VCNT_W    = 16;
   localparam int RWAIT_CYC = 2;

   typedef enum logic [3:0] {
      RECV  = 4'd0,
      HOLD  = 4'd1,
      LOAD  = 4'd2,
      CLKH  = 4'd3,
      CLKL  = 4'd4,
      GET   = 4'd5,
      RADDR = 4'd6,
      RWAIT = 4'd7,
      SEND  = 4'd8
   } state_t;

endpackage

`default_nettype wire

// File: rtl/emu_vec_sequencer_if.sv
// ---------------------------------------------------------------------------
// emu_vec_sequencer_if : host byte streams plus emulation wrapper bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface emu_vec_sequencer_if
   import emu_seq_pkg::*;
#(
   parameter int ADDR_W = 3
) ();

   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [BYTE_W-1:0] Din_emu;
   logic [BYTE_W-1:0] Dout_emu;
   logic [ADDR_W-1:0] Addr_emu;
   logic              load_emu;
   logic              get_emu;
   logic              clk_dut;

   modport master (
      input  rx_data, rx_valid, tx_ready, Dout_emu,
      output rx_ready, tx_data, tx_valid, Din_emu, Addr_emu,
             load_emu, get_emu, clk_dut
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, Dout_emu,
      input  rx_ready, tx_data, tx_valid, Din_emu, Addr_emu,
             load_emu, get_emu, clk_dut
   );

endinterface

`default_nettype wire

// File: rtl/emu_clk_pulse.sv
// ---------------------------------------------------------------------------
// emu_clk_pulse : one clk_dut period, CLK_HI cycles high then CLK_LO low
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module emu_clk_pulse #(
   parameter int CLK_HI = 1,
   parameter int CLK_LO = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic clk_dut,
   output logic done
);

   localparam int CNT_MAX = (CLK_HI > CLK_LO) ? CLK_HI : CLK_LO;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_HI   = 2'd1,
      PH_LO   = 2'd2
   } phase_t;

   phase_t           phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_q, clk_d;

   // done marks the final cycle of whichever phase is running
   assign done    = (phase_q != PH_IDLE) && (cnt_q == '0);
   assign clk_dut = clk_q;

   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      clk_d   = clk_q;
      unique case (phase_q)
         PH_IDLE: begin
            if (start) begin
               phase_d = PH_HI;
               cnt_d   = CNT_W'(CLK_HI - 1);
               clk_d   = 1'b1;
            end
         end
         PH_HI: begin
            if (cnt_q == '0) begin
               phase_d = PH_LO;
               cnt_d   = CNT_W'(CLK_LO - 1);
               clk_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         PH_LO: begin
            if (cnt_q == '0) phase_d = PH_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            phase_d = PH_IDLE;
            clk_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_IDLE;
         cnt_q   <= '0;
         clk_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         clk_q   <= clk_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/emu_vec_sequencer.sv
// ---------------------------------------------------------------------------
// emu_vec_sequencer : writes one stimulus vector, steps the DUT, returns outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module emu_vec_sequencer
   import emu_seq_pkg::*;
#(
   parameter int NUM_STIM = 3,
   parameter int NUM_OUT  = 2,
   parameter int ADDR_W   = 3,
   parameter int CLK_HI   = 1,
   parameter int CLK_LO   = 1
) (
   input  logic                clk_emu,
   input  logic                rst_n,
   emu_vec_sequencer_if.master bus,
   output logic                busy,
   output logic [VCNT_W-1:0]   vec_count
);

   localparam logic [ADDR_W-1:0] STIM_LAST = ADDR_W'(NUM_STIM - 1);
   localparam logic [ADDR_W:0]   OUT_NUM   = (ADDR_W + 1)'(NUM_OUT);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     j_q, j_d, j_inc;
   logic [1:0]          wait_q, wait_d;
   logic [BYTE_W-1:0]   din_q, din_d;
   logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
   logic                rx_ready_q, rx_ready_d;
   logic                tx_valid_q, tx_valid_d;
   logic                load_q, load_d;
   logic                get_q, get_d;
   logic                busy_q, busy_d;
   logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
   logic                pulse_start;
   logic                pulse_done;

   assign pulse_start = (state_q == LOAD);
   assign j_inc       = j_q + 1'b1;

   emu_clk_pulse #(
      .CLK_HI (CLK_HI),
      .CLK_LO (CLK_LO)
   ) u_clk_pulse (
      .clk     (clk_emu),
      .rst_n   (rst_n),
      .start   (pulse_start),
      .clk_dut (bus.clk_dut),
      .done    (pulse_done)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      j_d        = j_q;
      wait_d     = wait_q;
      din_d      = din_q;
      tx_data_d  = tx_data_q;
      rx_ready_d = rx_ready_q;
      tx_valid_d = tx_valid_q;
      load_d     = 1'b0;
      get_d      = 1'b0;
      vcnt_d     = vcnt_q;
      unique case (state_q)
         RECV: begin
            if (bus.rx_valid && rx_ready_q) begin
               addr_d = idx_q;
               din_d  = bus.rx_data;
               idx_d  = idx_q + 1'b1;
               if (idx_q == STIM_LAST) begin
                  state_d    = HOLD;
                  rx_ready_d = 1'b0;
               end
            end
         end
         HOLD: begin
            state_d = LOAD;
            load_d  = 1'b1;
         end
         LOAD: state_d = CLKH;
         CLKH: if (pulse_done) state_d = CLKL;
         CLKL: begin
            if (pulse_done) begin
               state_d = GET;
               get_d   = 1'b1;
            end
         end
         // Address goes out on entry to RADDR so RADDR+RWAIT span RWAIT_CYC cycles
         GET: begin
            state_d = RADDR;
            addr_d  = j_q[ADDR_W-1:0];
         end
         RADDR: begin
            state_d = RWAIT;
            wait_d  = 2'(RWAIT_CYC - 2);
         end
         RWAIT: begin
            if (wait_q == 2'd0) begin
               tx_data_d  = bus.Dout_emu;
               tx_valid_d = 1'b1;
               state_d    = SEND;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         SEND: begin
            if (bus.tx_ready) begin
               tx_valid_d = 1'b0;
               if (j_inc < OUT_NUM) begin
                  j_d     = j_inc;
                  addr_d  = j_inc[ADDR_W-1:0];
                  state_d = RADDR;
               end else begin
                  j_d        = '0;
                  idx_d      = '0;
                  vcnt_d     = vcnt_q + 1'b1;
                  rx_ready_d = 1'b1;
                  state_d    = RECV;
               end
            end
         end
         default: begin
            state_d    = RECV;
            rx_ready_d = 1'b1;
            tx_valid_d = 1'b0;
            idx_d      = '0;
            j_d        = '0;
         end
      endcase
      busy_d = (state_d != RECV);
   end

   always_ff @(posedge clk_emu or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RECV;
         idx_q      <= '0;
         addr_q     <= '0;
         j_q        <= '0;
         wait_q     <= '0;
         din_q      <= '0;
         tx_data_q  <= '0;
         rx_ready_q <= 1'b1;
         tx_valid_q <= 1'b0;
         load_q     <= 1'b0;
         get_q      <= 1'b0;
         busy_q     <= 1'b0;
         vcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         j_q        <= j_d;
         wait_q     <= wait_d;
         din_q      <= din_d;
         tx_data_q  <= tx_data_d;
         rx_ready_q <= rx_ready_d;
         tx_valid_q <= tx_valid_d;
         load_q     <= load_d;
         get_q      <= get_d;
         busy_q     <= busy_d;
         vcnt_q     <= vcnt_d;
      end
   end

   assign bus.rx_ready = rx_ready_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.Din_emu  = din_q;
   assign bus.Addr_emu = addr_q;
   assign bus.load_emu = load_q;
   assign bus.get_emu  = get_q;
   assign busy         = busy_q;
   assign vec_count    = vcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_emu_vec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_emu_vec_sequencer : directed checks against a behavioural wrapper model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_emu_vec_sequencer;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc   = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          acc_cyc = 0;
   bit          excl_err = 1'b0;
   int          ph_hi [2];
   int          ph_lo [2];
   bit          ph_act [2];

   logic        busy1, busy2;
   logic [15:0] vc1, vc2;

   emu_vec_sequencer_if #(.ADDR_W(3)) bus1 ();
   emu_vec_sequencer_if #(.ADDR_W(3)) bus2 ();

   emu_vec_sequencer #(
      .NUM_STIM (3), .NUM_OUT (2), .ADDR_W (3), .CLK_HI (1), .CLK_LO (1)
   ) u_dut1 (
      .clk_emu   (clk),
      .rst_n     (rst_n),
      .bus       (bus1),
      .busy      (busy1),
      .vec_count (vc1)
   );

   emu_vec_sequencer #(
      .NUM_STIM (3), .NUM_OUT (2), .ADDR_W (3), .CLK_HI (3), .CLK_LO (2)
   ) u_dut2 (
      .clk_emu   (clk),
      .rst_n     (rst_n),
      .bus       (bus2),
      .busy      (busy2),
      .vec_count (vc2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Wrapper model: idle-cycle stimIn write, load/get transfers, registered read.
   // The emulated DUT is a multiply-accumulate PE: y = x*w + acc.
   logic [7:0]  stim   [3];
   logic [7:0]  dut_in [3];
   logic [7:0]  vout   [2];
   logic [15:0] y;

   always @(posedge clk) begin
      if (bus1.load_emu) begin
         for (int i = 0; i < 3; i++) dut_in[i] <= stim[i];
      end else if (!bus1.get_emu && bus1.Addr_emu < 3'd3) begin
         stim[bus1.Addr_emu[1:0]] <= bus1.Din_emu;
      end
      if (bus1.get_emu) begin
         vout[0] <= y[7:0];
         vout[1] <= y[15:8];
      end
      bus1.Dout_emu <= (bus1.Addr_emu < 3'd2) ? vout[bus1.Addr_emu[0]] : 8'h00;
   end

   always @(posedge bus1.clk_dut)
      y <= ({8'h00, dut_in[0]} * {8'h00, dut_in[1]}) + {8'h00, dut_in[2]};

   always @(posedge clk) bus2.Dout_emu <= 8'hA0 | {5'd0, bus2.Addr_emu};

   always @(negedge clk) begin
      if ($countones({bus1.load_emu, bus1.get_emu, bus1.clk_dut}) > 1) excl_err = 1'b1;
      if ($countones({bus2.load_emu, bus2.get_emu, bus2.clk_dut}) > 1) excl_err = 1'b1;
      if (!busy1 && (bus1.load_emu || bus1.get_emu || bus1.clk_dut)) excl_err = 1'b1;
      if (!busy2 && (bus2.load_emu || bus2.get_emu || bus2.clk_dut)) excl_err = 1'b1;
      if (bus1.load_emu) begin
         ph_act[0] = 1'b1; ph_hi[0] = 0; ph_lo[0] = 0;
      end else if (ph_act[0]) begin
         if (bus1.get_emu)      ph_act[0] = 1'b0;
         else if (bus1.clk_dut) ph_hi[0]++;
         else                   ph_lo[0]++;
      end
      if (bus2.load_emu) begin
         ph_act[1] = 1'b1; ph_hi[1] = 0; ph_lo[1] = 0;
      end else if (ph_act[1]) begin
         if (bus2.get_emu)      ph_act[1] = 1'b0;
         else if (bus2.clk_dut) ph_hi[1]++;
         else                   ph_lo[1]++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic rx_rdy(input int s);
      return (s == 0) ? bus1.rx_ready : bus2.rx_ready;
   endfunction

   function automatic logic tx_vld(input int s);
      return (s == 0) ? bus1.tx_valid : bus2.tx_valid;
   endfunction

   // Called at a negedge; returns at the negedge following the accepting posedge.
   task automatic send_byte(input int s, input logic [7:0] b);
      int t = 0;
      if (s == 0) begin bus1.rx_data = b; bus1.rx_valid = 1'b1; end
      else        begin bus2.rx_data = b; bus2.rx_valid = 1'b1; end
      while (!rx_rdy(s) && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("rx_ready_timeout", 32'(t), 32'd0);
      @(negedge clk);
      acc_cyc = cyc;
      if (s == 0) bus1.rx_valid = 1'b0;
      else        bus2.rx_valid = 1'b0;
   endtask

   task automatic recv_byte(input int s, output logic [7:0] d, output int vcyc);
      int t = 0;
      if (s == 0) bus1.tx_ready = 1'b1;
      else        bus2.tx_ready = 1'b1;
      while (!tx_vld(s) && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("tx_valid_timeout", 32'(t), 32'd0);
      vcyc = cyc;
      d    = (s == 0) ? bus1.tx_data : bus2.tx_data;
      @(negedge clk);
   endtask

   task automatic run_vec(input int s, input logic [7:0] b0, b1, b2, e0, e1, input int lat);
      logic [7:0] d;
      int         vc;
      send_byte(s, b0);
      send_byte(s, b1);
      send_byte(s, b2);
      recv_byte(s, d, vc);
      check("latency", 32'(vc - acc_cyc), 32'(lat));
      check("tx_byte0", {24'd0, d}, {24'd0, e0});
      recv_byte(s, d, vc);
      check("tx_byte1", {24'd0, d}, {24'd0, e1});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, expected end earlier", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] d, d0;
      logic [2:0] a0;
      logic [7:0] di0;
      int         vc, t;
      bit         bad;

      bus1.rx_data = '0; bus1.rx_valid = 1'b0; bus1.tx_ready = 1'b0;
      bus2.rx_data = '0; bus2.rx_valid = 1'b0; bus2.tx_ready = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_rx_ready",  bus1.rx_ready, 1);
      check("rst_tx_valid",  bus1.tx_valid, 0);
      check("rst_tx_data",   bus1.tx_data,  0);
      check("rst_load",      bus1.load_emu, 0);
      check("rst_get",       bus1.get_emu,  0);
      check("rst_clk_dut",   bus1.clk_dut,  0);
      check("rst_addr",      bus1.Addr_emu, 0);
      check("rst_din",       bus1.Din_emu,  0);
      check("rst_busy",      busy1,         0);
      check("rst_vec_count", vc1,           0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single vector, back-to-back bytes: 0x35*0x21 + 0x01 = 0x06D6
      send_byte(0, 8'h35);
      check("v1_addr0", bus1.Addr_emu, 0);
      check("v1_din0",  bus1.Din_emu,  8'h35);
      send_byte(0, 8'h21);
      check("v1_addr1", bus1.Addr_emu, 1);
      check("v1_din1",  bus1.Din_emu,  8'h21);
      send_byte(0, 8'h01);
      check("v1_addr2",  bus1.Addr_emu, 2);
      check("v1_din2",   bus1.Din_emu,  8'h01);
      check("v1_rx_rdy", bus1.rx_ready, 0);
      check("v1_busy",   busy1,         1);
      recv_byte(0, d, vc);
      check("v1_latency", 32'(vc - acc_cyc), 7);
      check("v1_tx0", d, 8'hD6);
      recv_byte(0, d, vc);
      check("v1_tx1",      d,         8'h06);
      check("v1_clk_hi",   ph_hi[0],  1);
      check("v1_clk_lo",   ph_lo[0],  1);
      check("v1_vec_cnt",  vc1,       1);
      check("v1_rx_rdy_back", bus1.rx_ready, 1);

      // Backpressure on the first response byte: 0x02*0x03 + 0x04 = 0x000A
      send_byte(0, 8'h02);
      send_byte(0, 8'h03);
      send_byte(0, 8'h04);
      bus1.tx_ready = 1'b0;
      t = 0;
      while (!bus1.tx_valid && t < 200) begin @(negedge clk); t++; end
      check("bp_wait", 32'(t < 200), 1);
      d0  = bus1.tx_data;
      bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (!bus1.tx_valid || bus1.tx_data != d0 || bus1.rx_ready || bus1.Addr_emu != 3'd0)
            bad = 1'b1;
      end
      check("bp_stable", bad, 0);
      check("bp_tx0",    d0,  8'h0A);
      bus1.tx_ready = 1'b1;
      @(negedge clk);
      check("bp_addr_adv",  bus1.Addr_emu, 1);
      check("bp_valid_drop", bus1.tx_valid, 0);
      recv_byte(0, d, vc);
      check("bp_tx1",     d,   8'h00);
      check("bp_vec_cnt", vc1, 2);

      // Gaps of 4 idle cycles between stimulus bytes
      bad = 1'b0;
      foreach (stim[i]) begin
         send_byte(0, (i == 0) ? 8'h35 : (i == 1) ? 8'h21 : 8'h01);
         if (i < 2) begin
            a0  = bus1.Addr_emu;
            di0 = bus1.Din_emu;
            repeat (4) begin
               @(negedge clk);
               if (bus1.Addr_emu != a0 || bus1.Din_emu != di0) bad = 1'b1;
            end
         end
      end
      recv_byte(0, d, vc);
      check("gap_tx0", d, 8'hD6);
      recv_byte(0, d, vc);
      check("gap_tx1",    d,   8'h06);
      check("gap_stable", bad, 0);
      check("gap_stim_at_load", {dut_in[0], dut_in[1], dut_in[2]}, 24'h352101);
      check("gap_vec_cnt", vc1, 3);

      // Reset during the clk_dut high phase
      send_byte(0, 8'h11);
      send_byte(0, 8'h22);
      send_byte(0, 8'h33);
      t = 0;
      while (!bus1.clk_dut && t < 50) begin @(posedge clk); #1; t++; end
      check("rst_mid_reach_clkh", bus1.clk_dut, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_clk_dut",  bus1.clk_dut,  0);
      check("rst_mid_rx_ready", bus1.rx_ready, 1);
      check("rst_mid_vec_cnt",  vc1,           0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(0, 8'h35, 8'h21, 8'h01, 8'hD6, 8'h06, 7);
      check("rst_mid_after_vec_cnt", vc1, 1);

      // Stream of four vectors
      do_reset();
      excl_err = 1'b0;
      run_vec(0, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h00, 7);
      run_vec(0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 7);
      run_vec(0, 8'h10, 8'h10, 8'h00, 8'h00, 8'h01, 7);
      run_vec(0, 8'h80, 8'h02, 8'h7F, 8'h7F, 8'h01, 7);
      check("stream_vec_cnt", vc1, 4);

      // Wider clk_dut pulse build: 3 high, 2 low, latency 5+3+2
      run_vec(1, 8'h01, 8'h02, 8'h03, 8'hA0, 8'hA1, 10);
      check("wide_clk_hi",  ph_hi[1], 3);
      check("wide_clk_lo",  ph_lo[1], 2);
      check("wide_vec_cnt", vc2,      1);
      check("exclusive_strobes", excl_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
